// File: rtl/addsub_serial_pkg.sv
// Shared constants for addsub_serial: flag bit positions, op encodings and FSM states.
package addsub_serial_pkg;

    localparam int FLAG_ZF = 0;
    localparam int FLAG_SF = 1;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial.
// in_* pair: a transfer happens on a rising edge where in_valid && in_ready (same for out_*);
// the producer holds its payload stable while valid is high and ready is low.
interface addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry-in, carry-out and the carry into its MSB.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = full[CHUNK-1:0];
    assign cout  = full[CHUNK];
    // sum[msb] = a ^ b ^ carry_in, so the carry into the MSB falls out without a second adder
    assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle LSB-first add/subtract with ZF/SF/CF/OF flags, CHUNK bits per cycle.
// Optional ADDSUB_SAT_EN clamps the result on signed overflow.
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic   clk,
    input  logic   reset,
    addsub_serial_if.slave bus,
    output state_e state_dbg
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry;
    logic             op_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       flags_r;

    logic             accept, last;
    logic             in_ready_c, out_valid_c;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout, ch_c_msb;
    logic [WIDTH-1:0] res_next, fin_res;
    logic             of_w, cf_w;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_sh[CHUNK-1:0]),
        .b     (b_sh[CHUNK-1:0]),
        .cin   (carry),
        .sum   (ch_sum),
        .cout  (ch_cout),
        .c_msb (ch_c_msb)
    );

    assign accept   = (state == ST_IDLE) && bus.in_valid;
    assign last     = (state == ST_RUN) && (cnt == CW'(N - 1));
    assign res_next = (res_sh >> CHUNK) | (WIDTH'(ch_sum) << (WIDTH - CHUNK));
    assign of_w     = ch_c_msb ^ ch_cout;
    // Subtraction runs as A + ~B + 1, so a missing carry-out means a borrow
    assign cf_w     = (op_r == OP_SUB) ? ~ch_cout : ch_cout;

`ifdef ADDSUB_SAT_EN
    // On overflow the wrapped sign is the opposite of the true sign
    assign fin_res = of_w ? (res_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                               : {1'b1, {(WIDTH-1){1'b0}}})
                          : res_next;
`else
    assign fin_res = res_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            op_r     <= OP_ADD;
            cnt      <= '0;
            result_r <= '0;
            flags_r  <= '0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
            carry <= bus.op;
            op_r  <= bus.op;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> CHUNK;
            b_sh   <= b_sh >> CHUNK;
            res_sh <= res_next;
            carry  <= ch_cout;
            cnt    <= cnt + 1'b1;
            if (last) begin
                result_r         <= fin_res;
                flags_r[FLAG_ZF] <= (fin_res == '0);
                flags_r[FLAG_SF] <= fin_res[WIDTH-1];
                flags_r[FLAG_CF] <= cf_w;
                flags_r[FLAG_OF] <= of_w;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = result_r;
    assign bus.flags     = flags_r;
    assign state_dbg     = state;
endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=16, CHUNK=4) against an integer reference model.
module tb_addsub_serial;
    import addsub_serial_pkg::*;

    localparam int W = 16;

    logic   clk;
    logic   reset;
    state_e state_dbg;
    int     chk_cnt  = 0;
    int     pass_cnt = 0;
    logic [W+3:0] exp_q[$];

    addsub_serial_if #(.WIDTH(W)) bus ();

    addsub_serial #(.WIDTH(W), .CHUNK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {OF, CF, SF, ZF, result}
    function automatic logic [W+3:0] ref_model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ux = x, uy = y;
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ru, rs;
        logic [W-1:0] r;
        logic cf, of;
        ru = o ? ux - uy : ux + uy;
        rs = o ? sx - sy : sx + sy;
        cf = o ? (ux < uy) : (ru > 65535);
        of = (rs > 32767) || (rs < -32768);
        r  = W'(ru & 64'hFFFF);
`ifdef ADDSUB_SAT_EN
        if (of) r = (rs > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {of, cf, r[W-1], (r == 0), r};
    endfunction

    task automatic send_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, output bit to);
        int n = 0;
        to = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) to = 1;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a  = x;
        bus.b  = y;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit to);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 40);
        to = !bus.out_valid;
    endtask

    task automatic take_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.result !== 16'h0) $display("FAIL reset_result got=%h exp=0000", bus.result); else pass_cnt++;
        chk_cnt++; if (bus.flags !== 4'h0) $display("FAIL reset_flags got=%b exp=0000", bus.flags); else pass_cnt++;
        chk_cnt++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic        ops [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] xa [4] = '{16'h1234, 16'h0005, 16'h0003, 16'h7FFF};
        logic [W-1:0] xb [4] = '{16'h0001, 16'h0005, 16'h0005, 16'h0001};
        logic [W+3:0] e;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            e = ref_model(ops[i], xa[i], xb[i]);
            send_op(ops[i], xa[i], xb[i], to);
            wait_done(lat, to);
            chk_cnt++; if (to) $display("FAIL dir%0d_timeout out_valid never rose", i); else pass_cnt++;
            chk_cnt++; if (lat !== 4) $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); else pass_cnt++;
            chk_cnt++; if (bus.result !== e[W-1:0]) $display("FAIL dir%0d_result got=%h exp=%h", i, bus.result, e[W-1:0]); else pass_cnt++;
            chk_cnt++; if (bus.flags !== e[W+3:W]) $display("FAIL dir%0d_flags got=%b exp=%b", i, bus.flags, e[W+3:W]); else pass_cnt++;
            take_result();
        end
    endtask

    task automatic test_random();
        logic         o;
        logic [W-1:0] x, y;
        logic [W+3:0] e;
        int lat;
        bit to;
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            x = 16'($urandom_range(0, 65535));
            y = 16'($urandom_range(0, 65535));
            if (i % 6 == 0) y = x;
            if (i % 6 == 1) x = 16'h8000;
            exp_q.push_back(ref_model(o, x, y));
            send_op(o, x, y, to);
            wait_done(lat, to);
            e = exp_q.pop_front();
            chk_cnt++;
            if (to || {bus.flags, bus.result} !== e)
                $display("FAIL rand%0d op=%b a=%h b=%h got=%b_%h exp=%b_%h", i, o, x, y, bus.flags, bus.result, e[W+3:W], e[W-1:0]);
            else pass_cnt++;
            take_result();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r0;
        logic [3:0]   f0;
        logic [W+3:0] e;
        int lat;
        bit to;
        send_op(1'b0, 16'hF00F, 16'h1001, to);
        wait_done(lat, to);
        r0 = bus.result;
        f0 = bus.flags;
        e  = ref_model(1'b1, 16'h4000, 16'hC000);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 1'b1;
        bus.a  = 16'h4000;
        bus.b  = 16'hC000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== r0 || bus.flags !== f0)
                $display("FAIL bp_hold%0d got v=%b rdy=%b r=%h f=%b exp v=1 rdy=0 r=%h f=%b",
                         i, bus.out_valid, bus.in_ready, bus.result, bus.flags, r0, f0);
            else pass_cnt++;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== r0)
            $display("FAIL bp_release got rdy=%b v=%b r=%h exp rdy=1 v=0 r=%h", bus.in_ready, bus.out_valid, bus.result, r0);
        else pass_cnt++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_accept in_ready got=%b exp=0", bus.in_ready); else pass_cnt++;
        wait_done(lat, to);
        chk_cnt++;
        if (to || lat !== 4 || {bus.flags, bus.result} !== e)
            $display("FAIL bp_next got lat=%0d %b_%h exp lat=4 %b_%h", lat, bus.flags, bus.result, e[W+3:W], e[W-1:0]);
        else pass_cnt++;
        take_result();
    endtask

    task automatic test_reset_mid();
        logic [W+3:0] e;
        int lat;
        bit to;
        send_op(1'b0, 16'h7FFF, 16'h7FFF, to);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 16'h0 || bus.flags !== 4'h0)
            $display("FAIL mid_reset got rdy=%b v=%b r=%h f=%b exp rdy=1 v=0 r=0000 f=0000",
                     bus.in_ready, bus.out_valid, bus.result, bus.flags);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_no_partial out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
        end
        e = ref_model(1'b1, 16'h0100, 16'h0001);
        send_op(1'b1, 16'h0100, 16'h0001, to);
        wait_done(lat, to);
        chk_cnt++;
        if (to || bus.result !== 16'h00FF || {bus.flags, bus.result} !== e)
            $display("FAIL mid_after got=%b_%h exp=%b_%h", bus.flags, bus.result, e[W+3:W], e[W-1:0]);
        else pass_cnt++;
        take_result();
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
